// File: rtl/raster_output_queue_pkg.sv
// Shared types for the raster-unit output queue: the record carried from the
// raster unit, the FWFT head-register state and the default sizing.
package raster_output_queue_pkg;

   localparam int RASTER_OUTPUT_QUEUE_DEPTH   = 4;
   localparam int RASTER_OUTPUT_QUEUE_RESERVE = 1;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [31:0] depth;
      logic [15:0] prim_id;
   } RasterOutputData;

   typedef enum logic {
      RQS_Empty = 1'b0,
      RQS_Head  = 1'b1
   } RasterQueueState;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/raster_queue_mem.sv
// DEPTH x WIDTH storage array with one write port and one registered read port;
// the read register doubles as the queue's head register.
module raster_queue_mem
   import raster_output_queue_pkg::*;
#(
   parameter int DEPTH = RASTER_OUTPUT_QUEUE_DEPTH,
   parameter int WIDTH = $bits(RasterOutputData)
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     wr_en_i,
   input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     rd_en_i,
   input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
   output logic [WIDTH-1:0]         rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Only the read register is reset, so an aborted transfer never leaves a stale head visible.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/raster_output_queue.sv
// Receiving FIFO for raster-unit output records with FWFT valid/ready output.
// Optional statistics counters are enabled by defining RASTER_OUTPUT_QUEUE_STATS_EN.
module raster_output_queue
   import raster_output_queue_pkg::*;
#(
   parameter int DEPTH   = RASTER_OUTPUT_QUEUE_DEPTH,
   parameter int RESERVE = RASTER_OUTPUT_QUEUE_RESERVE
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            in_valid,
   input  RasterOutputData in_data,
   output logic            fifo_full,
   output logic            out_valid,
   output RasterOutputData out_data,
   input  logic            out_ready,
   output logic            overflow
`ifdef RASTER_OUTPUT_QUEUE_STATS_EN
   ,
   output logic [31:0]     stat_pushed,
   output logic [31:0]     stat_popped,
   output logic [31:0]     stat_max_level
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int W  = $bits(RasterOutputData);
   localparam logic [CW-1:0] DEPTH_LVL = CW'(DEPTH);
   localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH - RESERVE);

   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            fifo_full_q;
   logic            overflow_q;
   RasterQueueState state_q, state_d;
   logic            push, pop, head_load;
   logic [W-1:0]    head_data;

   always_comb begin
      pop      = (state_q == RQS_Head) && out_ready;
      push     = in_valid && ((count_q != DEPTH_LVL) || pop);
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
      // A record pushed this edge is not readable until the next one, so only
      // entries already stored before the edge can refill the head register.
      head_load = ((state_q == RQS_Empty) && (count_q != '0)) ||
                  (pop && (count_q > CW'(1)));
      state_d = state_q;
      if (state_q == RQS_Empty) begin
         if (count_q != '0) state_d = RQS_Head;
      end else if (pop && (count_q == CW'(1))) begin
         state_d = RQS_Empty;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         fifo_full_q <= 1'b0;
         overflow_q  <= 1'b0;
         state_q     <= RQS_Empty;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         fifo_full_q <= (count_d >= FULL_LVL);
         state_q     <= state_d;
         if (in_valid && !push) begin
            overflow_q <= 1'b1;
         end
      end
   end

   raster_queue_mem #(
      .DEPTH (DEPTH),
      .WIDTH (W)
   ) u_mem (
      .clk       (clk),
      .resetn    (resetn),
      .wr_en_i   (push),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (in_data),
      .rd_en_i   (head_load),
      .rd_addr_i (rd_ptr_d),
      .rd_data_o (head_data)
   );

   assign out_data  = RasterOutputData'(head_data);
   assign out_valid = (state_q == RQS_Head);
   assign fifo_full = fifo_full_q;
   assign overflow  = overflow_q;

`ifdef RASTER_OUTPUT_QUEUE_STATS_EN
   logic [31:0] stat_pushed_q, stat_popped_q, stat_max_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stat_pushed_q <= '0;
         stat_popped_q <= '0;
         stat_max_q    <= '0;
      end else begin
         if (push) stat_pushed_q <= sat_inc(stat_pushed_q);
         if (pop)  stat_popped_q <= sat_inc(stat_popped_q);
         if (32'(count_d) > stat_max_q) stat_max_q <= 32'(count_d);
      end
   end

   assign stat_pushed    = stat_pushed_q;
   assign stat_popped    = stat_popped_q;
   assign stat_max_level = stat_max_q;
`endif

endmodule
